paddle_pos_ctrl: RTL and testbench

- Writer side of the paddle-position interface. Generates P1_y and P2_y, the top-row y of each 30x50 paddle, which the layer generator compares against v_cnt.
- Samples player buttons and moves each paddle once per frame, at the start of vertical blanking, so the picture never tears.
- Per-player motion FSM with slow/fast speed, and clamping to the visible area.

---
 rtl/paddle_pos_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_paddle_pos_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/paddle_pos_ctrl.sv
// paddle_pos_ctrl: writer side of the paddle-position interface.
// Moves each paddle at most once per frame, at the first vertical-blanking
// line, using a per-player IDLE/SLOW/FAST motion FSM with wall clamping.
// Optional build macro: PADDLE_AI_P2_EN (player 2 tracks ball_y, never FAST).
module paddle_pos_ctrl #(
    parameter int PADDLE_H     = 50,
    parameter int Y_TOP        = 0,
    parameter int Y_BOT        = 480,
    parameter int INIT_Y       = 215,
    parameter int UPD_LINE     = 480,
    parameter int STEP_SLOW    = 2,
    parameter int STEP_FAST    = 6,
    parameter int ACCEL_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    input  logic       p1_up,
    input  logic       p1_dn,
    input  logic       p2_up,
    input  logic       p2_dn,
`ifdef PADDLE_AI_P2_EN
    input  logic [9:0] ball_y,
`endif
    output logic [9:0] P1_y,
    output logic [9:0] P2_y,
    output logic       frame_upd
);

    typedef enum logic [1:0] {ST_IDLE, ST_SLOW, ST_FAST} state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

    localparam int          HOLD_W   = $clog2(ACCEL_FRAMES + 1);
    localparam logic [10:0] Y_MIN    = 11'(Y_TOP);
    localparam logic [10:0] Y_MAX    = 11'(Y_BOT - PADDLE_H);
    localparam logic [10:0] STEP_S   = 11'(STEP_SLOW);
    localparam logic [10:0] STEP_F   = 11'(STEP_FAST);
    localparam logic [9:0]  UPD_V    = 10'(UPD_LINE);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(ACCEL_FRAMES);
`ifdef PADDLE_AI_P2_EN
    localparam logic AI_P2 = 1'b1;
`else
    localparam logic AI_P2 = 1'b0;
`endif

    function automatic dir_t decode_dir(input logic up, input logic dn);
        if (up && !dn) return DIR_UP;
        if (dn && !up) return DIR_DN;
        return DIR_NONE;
    endfunction

    logic [3:0] r_btn_meta, r_btn_sync;
    logic       r_cond, r_cond_d;
    logic       w_upd;
    dir_t       w_dir_p1, w_dir_p2;
    logic [9:0] w_y [2];

    // Two-flop synchronizers for the asynchronous buttons.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_meta <= '0;
            r_btn_sync <= '0;
        end else begin
            r_btn_meta <= {p2_dn, p2_up, p1_dn, p1_up};
            r_btn_sync <= r_btn_meta;
        end
    end

    // Registered update condition and its delayed copy for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cond    <= 1'b0;
            r_cond_d  <= 1'b0;
            frame_upd <= 1'b0;
        end else begin
            r_cond    <= (v_cnt == UPD_V) && (h_cnt == 10'd0);
            r_cond_d  <= r_cond;
            frame_upd <= w_upd;
        end
    end

    // One update per frame even when the counters dwell on the update pixel.
    assign w_upd    = r_cond && !r_cond_d;
    assign w_dir_p1 = decode_dir(r_btn_sync[0], r_btn_sync[1]);

`ifdef PADDLE_AI_P2_EN
    logic [10:0] w_p2_ctr, w_ball;
    assign w_p2_ctr = {1'b0, w_y[1]} + 11'(PADDLE_H / 2);
    assign w_ball   = {1'b0, ball_y};

    // Player 2 steers its centre toward the ball, with a STEP_SLOW dead band.
    always_comb begin
        w_dir_p2 = DIR_NONE;
        if (w_p2_ctr > w_ball + STEP_S)
            w_dir_p2 = DIR_UP;
        else if (w_p2_ctr + STEP_S < w_ball)
            w_dir_p2 = DIR_DN;
    end
`else
    assign w_dir_p2 = decode_dir(r_btn_sync[2], r_btn_sync[3]);
`endif

    for (genvar g = 0; g < 2; g++) begin : g_player
        localparam logic FAST_OK = (g == 0) || !AI_P2;

        dir_t              w_dir;
        state_t            r_state, w_state_nx;
        logic [HOLD_W-1:0] r_hold, w_hold_nx;
        logic              r_dir_up, w_dir_up_nx;
        logic              w_move;
        logic [10:0]       w_step, w_y_ext;
        logic [9:0]        r_y, w_y_nx;

        assign w_dir    = (g == 0) ? w_dir_p1 : w_dir_p2;
        assign w_y_ext  = {1'b0, r_y};
        assign w_y[g]   = r_y;

        // Motion FSM next state, hold counter and clamped next position.
        always_comb begin
            // NOTE: every output gets a default first so no path can infer a latch.
            w_state_nx  = r_state;
            w_hold_nx   = r_hold;
            w_dir_up_nx = r_dir_up;
            w_move      = 1'b0;
            w_step      = STEP_S;
            w_y_nx      = r_y;

            unique case (r_state)
                ST_IDLE: begin
                    if (w_dir != DIR_NONE) begin
                        w_state_nx  = ST_SLOW;
                        w_hold_nx   = HOLD_W'(1);
                        w_dir_up_nx = (w_dir == DIR_UP);
                        w_move      = 1'b1;
                    end
                end
                ST_SLOW, ST_FAST: begin
                    if (w_dir == DIR_NONE) begin
                        w_state_nx = ST_IDLE;
                        w_hold_nx  = '0;
                    end else if ((w_dir == DIR_UP) != r_dir_up) begin
                        w_state_nx  = ST_SLOW;
                        w_hold_nx   = HOLD_W'(1);
                        w_dir_up_nx = (w_dir == DIR_UP);
                        w_move      = 1'b1;
                    end else if (r_state == ST_FAST) begin
                        w_step = STEP_F;
                        w_move = 1'b1;
                    end else begin
                        w_hold_nx = (r_hold == HOLD_MAX) ? r_hold : r_hold + 1'b1;
                        if (w_hold_nx == HOLD_MAX && FAST_OK)
                            w_state_nx = ST_FAST;
                        w_move = 1'b1;
                    end
                end
                default: w_state_nx = ST_IDLE;
            endcase

            if (w_move && w_dir_up_nx)
                w_y_nx = (w_y_ext < Y_MIN + w_step) ? Y_MIN[9:0] : r_y - w_step[9:0];
            else if (w_move)
                w_y_nx = (w_y_ext + w_step > Y_MAX) ? Y_MAX[9:0] : r_y + w_step[9:0];
        end

        // Commit FSM and position only on the frame update event.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state  <= ST_IDLE;
                r_hold   <= '0;
                r_dir_up <= 1'b0;
                r_y      <= 10'(INIT_Y);
            end else if (w_upd) begin
                r_state  <= w_state_nx;
                r_hold   <= w_hold_nx;
                r_dir_up <= w_dir_up_nx;
                r_y      <= w_y_nx;
            end
        end
    end

    assign P1_y = w_y[0];
    assign P2_y = w_y[1];

endmodule

// File: tb/tb_paddle_pos_ctrl.sv
// Self-checking bench for paddle_pos_ctrl: directed frames from the test plan
// followed by randomized frames, all checked against a streak-based model.
// Honors PADDLE_AI_P2_EN when defined for the AI player-2 build.
module tb_paddle_pos_ctrl;

    localparam int Y_MAX = 430;
    localparam int INIT  = 215;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] h_cnt = 10'd100;
    logic [9:0] v_cnt = 10'd100;
    logic       p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0;
    logic [9:0] ball_y = 10'd240;
    logic [9:0] P1_y, P2_y;
    logic       frame_upd;

    int checks = 0;
    int failures = 0;

    // Reference model state: position, run length of same non-zero direction, last direction.
    int m_y [2];
    int m_streak [2];
    int m_last [2];
    bit ai_p2;

    paddle_pos_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .p1_up     (p1_up),
        .p1_dn     (p1_dn),
        .p2_up     (p2_up),
        .p2_dn     (p2_dn),
`ifdef PADDLE_AI_P2_EN
        .ball_y    (ball_y),
`endif
        .P1_y      (P1_y),
        .P2_y      (P2_y),
        .frame_upd (frame_upd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int dir_of(input bit up, input bit dn);
        if (up && !dn) return -1;
        if (dn && !up) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_y[p] = INIT;
            m_streak[p] = 0;
            m_last[p] = 0;
        end
    endtask

    // One frame of the model: frames 1..ACCEL of a streak move 2, later frames 6.
    task automatic model_frame();
        int d, step;
        for (int p = 0; p < 2; p++) begin
            if (p == 0)
                d = dir_of(p1_up, p1_dn);
            else if (ai_p2) begin
                if (m_y[1] + 25 > int'(ball_y) + 2) d = -1;
                else if (m_y[1] + 25 + 2 < int'(ball_y)) d = 1;
                else d = 0;
            end else
                d = dir_of(p2_up, p2_dn);
            if (d == 0) m_streak[p] = 0;
            else if (d == m_last[p] && m_streak[p] > 0) m_streak[p]++;
            else m_streak[p] = 1;
            m_last[p] = d;
            step = (m_streak[p] > 8 && !(ai_p2 && p == 1)) ? 6 : 2;
            if (d < 0) m_y[p] = (m_y[p] - step < 0) ? 0 : m_y[p] - step;
            else if (d > 0) m_y[p] = (m_y[p] + step > Y_MAX) ? Y_MAX : m_y[p] + step;
        end
    endtask

    // Run one frame; returns how many cycles frame_upd was high and any off-update moves.
    task automatic run_frame(input bit [3:0] btn, input int dwell);
        int pulses, stray;
        logic [9:0] y1, y2;
        pulses = 0;
        stray = 0;
        {p2_dn, p2_up, p1_dn, p1_up} = btn;
        v_cnt = 10'd479;
        h_cnt = 10'd100;
        y1 = P1_y;
        y2 = P2_y;
        repeat (4) begin
            @(posedge clk); #1;
            pulses += int'(frame_upd);
            if (!frame_upd && (P1_y != y1 || P2_y != y2)) stray++;
            y1 = P1_y; y2 = P2_y;
        end
        v_cnt = 10'd480;
        h_cnt = 10'd0;
        repeat (dwell) begin
            @(posedge clk); #1;
            pulses += int'(frame_upd);
            if (!frame_upd && (P1_y != y1 || P2_y != y2)) stray++;
            y1 = P1_y; y2 = P2_y;
        end
        h_cnt = 10'd1;
        repeat (3) begin
            @(posedge clk); #1;
            pulses += int'(frame_upd);
            if (!frame_upd && (P1_y != y1 || P2_y != y2)) stray++;
            y1 = P1_y; y2 = P2_y;
        end
        model_frame();
        check("upd_pulses", pulses, 1);
        check("y_stable", stray, 0);
        check("p1_y", int'(P1_y), m_y[0]);
        check("p2_y", int'(P2_y), m_y[1]);
    endtask

    task automatic mid_frame_reset();
        int pulses;
        pulses = 0;
        v_cnt = 10'd200;
        h_cnt = 10'd300;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("rst_p1_y", int'(P1_y), INIT);
        check("rst_p2_y", int'(P2_y), INIT);
        check("rst_upd", int'(frame_upd), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        repeat (6) begin
            @(posedge clk); #1;
            pulses += int'(frame_upd);
        end
        check("rst_no_upd", pulses, 0);
    endtask

    initial begin
        bit [3:0] btn;
`ifdef PADDLE_AI_P2_EN
        ai_p2 = 1'b1;
`else
        ai_p2 = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init_p1_y", int'(P1_y), INIT);
        check("init_p2_y", int'(P2_y), INIT);
        check("init_upd", int'(frame_upd), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single update with a long dwell on the update pixel.
        run_frame(4'b0010, 4);
        check("single_p1", int'(P1_y), 217);
        check("single_p2", int'(P2_y), 215);
        run_frame(4'b0000, 1);

        mid_frame_reset();

        // Acceleration: eight slow frames then fast.
        for (int f = 0; f < 10; f++) run_frame(4'b0001, 1 + f % 3);
        check("accel_p1", int'(P1_y), 187);
        // Reversal out of FAST moves STEP_SLOW.
        run_frame(4'b0010, 2);
        check("reverse_p1", int'(P1_y), 189);
        // Both buttons pressed: no move.
        run_frame(4'b0011, 1);
        check("conflict_p1", int'(P1_y), 189);

        // Clamp both walls; keep pushing once pinned.
        for (int f = 0; f < 50; f++) run_frame(4'b0110, 2);
        check("clamp_p1", int'(P1_y), 430);
`ifndef PADDLE_AI_P2_EN
        check("clamp_p2", int'(P2_y), 0);
`endif

        // Randomized frames with sticky buttons so streaks form.
        btn = 4'b0000;
        for (int f = 0; f < 150; f++) begin
            if ($urandom_range(3) == 0) btn = 4'($urandom);
            if ($urandom_range(4) == 0) ball_y = 10'($urandom_range(479));
            run_frame(btn, $urandom_range(1, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
